prng_tile_pixel_gen: RTL and testbench
======================================

// Module: prng_tile_pixel_gen
// PURPOSE
//  Pixel source directly upstream of the VGA driver. Consumes the driver's next-pixel coordinates.
//  Returns an RGB332 colour for the driver's colour input.
//  Screen is tiled in 2^TILE_LOG2-square tiles; each tile colour comes from a 16-bit LFSR.
//  Pattern is stable within a frame and re-seeded every FRAMES_PER_UPDATE frames (animated noise).
// PARAMETERS
//  ACTIVE_HORIZONTAL  640     active pixels per line
//  ACTIVE_VERTICAL    480     active lines per frame
//  TILE_LOG2          4       tile edge = 2^TILE_LOG2 pixels; NCOL = ACTIVE_HORIZONTAL>>TILE_LOG2
//  SEED               16'hACE1 initial frame seed; 0 is replaced by 16'h0001
//  FRAMES_PER_UPDATE  60      frame starts between seed advances (>=1)
//  W_COLOR            8       colour width (RGB332)
// PORTS
//  i_clk         in   1        pixel clock
//  i_rst         in   1        asynchronous reset, active-high
//  i_x_cor       in   10       next-pixel x from driver (0 outside active area)
//  i_y_cor       in   10       next-pixel y from driver (0 outside active area)
//  i_hold        in   1        1 = freeze seed (frame counter paused)
//  o_color       out  W_COLOR  RGB332 colour {R[2:0],G[2:0],B[1:0]}, registered
//  o_frame_start out  1        1-cycle pulse on frame-start event
// BEHAVIOUR
//  Reset values: o_color=0, o_frame_start=0, seed=SEED, lfsr=SEED, frame_cnt=0, state=ST_IDLE, x_q/y_q=0.
//  Events (from registered x_q/y_q vs inputs):
//   - frame_start: y_q!=0 && i_y_cor==0.
//   - row_evt: i_y_cor!=y_q.
//   - col_evt: i_x_cor[9:TILE_LOG2]!=x_q[9:TILE_LOG2].
//  LFSR step: nxt(s) = {s[14:0], s[15]^s[13]^s[12]^s[10]}; never reaches 0.
//  Tile generation in a fill row:
//   - new colour = lfsr[7:0]; written to line_buf[col]; lfsr <= nxt(lfsr).
//   - On frame_start: colour = seed[7:0] and lfsr <= nxt(seed); load wins over a concurrent step.
//  FSM:
//   - ST_IDLE: o_color=0; on first frame_start -> ST_FILL.
//   - ST_FILL: i_y_cor[TILE_LOG2-1:0]==0. Generate on row_evt (col 0) and each col_evt; else hold current tile colour.
//   - ST_REPLAY: other lines of a tile row; colour = line_buf[i_x_cor>>TILE_LOG2]; LFSR idle.
//   - row_evt with low y bits==0 -> ST_FILL; other row_evt -> ST_REPLAY; frame_start always -> ST_FILL.
//  Latency: o_color valid exactly 1 cycle after the coordinate it belongs to.
//   line_buf is read combinationally, output register only.
//  frame_cnt: increments on frame_start unless i_hold.
//   - At FRAMES_PER_UPDATE-1 it wraps to 0 and seed <= nxt(seed).
//   - New seed takes effect at the next frame_start.
//  i_hold: asserted mid-frame freezes frame_cnt only; the current frame still completes normally.
//  Out-of-range col (>=NCOL): write suppressed, read returns 0.
//  Reset mid-line: all state cleared; output 0 until next frame_start.
// CONFIGURATION
//  PRNG_TILE_GRID_EN defined:
//   - o_color forced to 8'hFF when i_x_cor[TILE_LOG2-1:0]==0 or i_y_cor[TILE_LOG2-1:0]==0.
//   - Forcing applies in ST_FILL/ST_REPLAY only; LFSR/buffer sequencing unchanged.
//  PRNG_TILE_GRID_EN undefined: no overlay; no grid logic present.
// STRUCTURE
//  prng_vga_pkg:
//   - typedef rgb332_t.
//   - localparams COORD_W=10, LFSR_W=16, LFSR_TAPS.
//   - function lfsr_next().
//   - state enum {ST_IDLE, ST_FILL, ST_REPLAY}.
//  Sub-module lfsr16_step: combinational nxt(s), shared by seed and tile LFSR paths.
//  line_buf: NCOL x W_COLOR register array inside this module.
// TESTING
//  1. i_rst=1 mid-stream -> o_color=0, o_frame_start=0 immediately; state ST_IDLE until frame_start.
//  2. Default params, y 479->0 -> o_frame_start pulse; tile(0,0)=8'hE1; tile(1,0) (x=16..31)=8'hC3 (nxt(ACE1)=59C3).
//  3. y=1..15 lines -> per-column colours identical to y=0 line, 1-cycle latency, no LFSR change.
//  4. 60 frames, i_hold=0 -> frame 61 tile(0,0)=8'hC3; with i_hold=1 throughout -> stays 8'hE1.
//  5. SEED=0 -> tile(0,0)=8'h01, no LFSR lock-up over 1000 steps.
//  6. PRNG_TILE_GRID_EN: x=16,y=5 -> 8'hFF; x=17,y=5 -> tile colour; undefined -> x=16 gives tile colour.

Source files
------------

// File: rtl/prng_vga_pkg.sv
// rtl/prng_vga_pkg.sv - shared types, constants and LFSR step function for the tile pixel source
package prng_vga_pkg;

   localparam int          COORD_W   = 10;
   localparam int          LFSR_W    = 16;
   // Feedback taps at bits 15, 13, 12 and 10 (maximal-length 16-bit Fibonacci LFSR)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef logic [7:0] rgb332_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_REPLAY = 2'd2
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr16_step.sv
// rtl/lfsr16_step.sv - combinational single step of the 16-bit tile LFSR
module lfsr16_step
   import prng_vga_pkg::*;
(
   input  logic [LFSR_W-1:0] i_state,
   output logic [LFSR_W-1:0] o_next
);

   assign o_next = lfsr_next(i_state);

endmodule

// File: rtl/prng_tile_pixel_gen.sv
// rtl/prng_tile_pixel_gen.sv - LFSR tiled noise pixel source; optional grid overlay via PRNG_TILE_GRID_EN
module prng_tile_pixel_gen
   import prng_vga_pkg::*;
#(
   parameter int          ACTIVE_HORIZONTAL = 640,
   parameter int          ACTIVE_VERTICAL   = 480,
   parameter int          TILE_LOG2         = 4,
   parameter logic [15:0] SEED              = 16'hACE1,
   parameter int          FRAMES_PER_UPDATE = 60,
   parameter int          W_COLOR           = 8
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [9:0]         i_x_cor,
   input  logic [9:0]         i_y_cor,
   input  logic               i_hold,
   output logic [W_COLOR-1:0] o_color,
   output logic               o_frame_start
);

   localparam int                NCOL     = ACTIVE_HORIZONTAL >> TILE_LOG2;
   localparam int                COL_W    = COORD_W - TILE_LOG2;
   localparam int                CNT_W    = $clog2(FRAMES_PER_UPDATE + 1);
   // An all-zero seed would lock the LFSR, so it is replaced by 1
   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   // Reject geometries the 10-bit coordinate bus cannot express
   if (FRAMES_PER_UPDATE < 1 || ACTIVE_VERTICAL < 1 || ACTIVE_VERTICAL > 1024 ||
       ACTIVE_HORIZONTAL > 1024 || W_COLOR > LFSR_W) begin : g_bad_cfg
      $error("prng_tile_pixel_gen: unsupported parameter set");
   end

   logic [COL_W-1:0]   r_xcol_q;
   logic [9:0]         r_y_q;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [LFSR_W-1:0]  r_lfsr;
   logic [LFSR_W-1:0]  r_seed;
   logic [CNT_W-1:0]   r_frame_cnt;
   logic [W_COLOR-1:0] r_cur_color;
   logic [W_COLOR-1:0] r_line_buf [0:NCOL-1];

   logic [COL_W-1:0]   w_col;
   logic               w_col_ok;
   logic               w_frame_start;
   logic               w_row_evt;
   logic               w_col_evt;
   logic               w_fill_line;
   logic [LFSR_W-1:0]  w_lfsr_nxt;
   logic [LFSR_W-1:0]  w_seed_nxt;
   logic               w_load;
   logic               w_step;
   logic               w_buf_we;
   logic [W_COLOR-1:0] w_tile_color;
   logic [W_COLOR-1:0] w_color;

   assign w_col         = i_x_cor[9:TILE_LOG2];
   assign w_col_ok      = ({1'b0, w_col} < (COL_W + 1)'(NCOL));
   assign w_frame_start = (r_y_q != 10'd0) && (i_y_cor == 10'd0);
   assign w_row_evt     = (i_y_cor != r_y_q);
   assign w_col_evt     = (w_col != r_xcol_q);
   assign w_fill_line   = (i_y_cor[TILE_LOG2-1:0] == '0);

   lfsr16_step u_tile_step (
      .i_state (r_lfsr),
      .o_next  (w_lfsr_nxt)
   );

   lfsr16_step u_seed_step (
      .i_state (r_seed),
      .o_next  (w_seed_nxt)
   );

   // Tile FSM next state plus the colour belonging to the coordinate presented this cycle
   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_buf_we     = 1'b0;
      w_tile_color = '0;
      if (w_frame_start) begin
         w_state_nxt = ST_FILL;
      end else if (r_state != ST_IDLE && w_row_evt) begin
         w_state_nxt = w_fill_line ? ST_FILL : ST_REPLAY;
      end
      case (w_state_nxt)
         ST_FILL: begin
            if (w_frame_start) begin
               w_load       = 1'b1;
               w_buf_we     = w_col_ok;
               w_tile_color = r_seed[W_COLOR-1:0];
            end else if (w_row_evt || w_col_evt) begin
               w_step       = 1'b1;
               w_buf_we     = w_col_ok;
               w_tile_color = r_lfsr[W_COLOR-1:0];
            end else begin
               w_tile_color = r_cur_color;
            end
         end
         ST_REPLAY: begin
            w_tile_color = w_col_ok ? r_line_buf[w_col] : '0;
         end
         default: begin
            w_tile_color = '0;
         end
      endcase
   end

`ifdef PRNG_TILE_GRID_EN
   // Tile borders are painted white while the pattern is active
   always_comb begin
      w_color = w_tile_color;
      if (w_state_nxt != ST_IDLE &&
          (i_x_cor[TILE_LOG2-1:0] == '0 || i_y_cor[TILE_LOG2-1:0] == '0)) begin
         w_color = {W_COLOR{1'b1}};
      end
   end
`else
   logic w_unused_x_lo;
   assign w_unused_x_lo = ^i_x_cor[TILE_LOG2-1:0];
   assign w_color       = w_tile_color;
`endif

   // Coordinate history and FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_xcol_q <= '0;
         r_y_q    <= '0;
         r_state  <= ST_IDLE;
      end else begin
         r_xcol_q <= w_col;
         r_y_q    <= i_y_cor;
         r_state  <= w_state_nxt;
      end
   end

   // Tile LFSR: frame-start reload takes priority over a generation step
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lfsr      <= SEED_EFF;
         r_cur_color <= '0;
      end else if (w_load) begin
         r_lfsr      <= w_seed_nxt;
         r_cur_color <= w_tile_color;
      end else if (w_step) begin
         r_lfsr      <= w_lfsr_nxt;
         r_cur_color <= w_tile_color;
      end
   end

   // Frame counter; seed advances on wrap and is first used at the following frame start
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_frame_cnt <= '0;
         r_seed      <= SEED_EFF;
      end else if (w_frame_start && !i_hold) begin
         if (r_frame_cnt == CNT_W'(FRAMES_PER_UPDATE - 1)) begin
            r_frame_cnt <= '0;
            r_seed      <= w_seed_nxt;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   // Line buffer captures each freshly generated tile colour of a fill line
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NCOL; i++) begin
            r_line_buf[i] <= '0;
         end
      end else if (w_buf_we) begin
         r_line_buf[w_col] <= w_tile_color;
      end
   end

   // Output register: one cycle behind the coordinate it belongs to
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_color       <= '0;
         o_frame_start <= 1'b0;
      end else begin
         o_color       <= w_color;
         o_frame_start <= w_frame_start;
      end
   end

endmodule

// File: tb/tb_prng_tile_pixel_gen.sv
// tb/tb_prng_tile_pixel_gen.sv - scoreboard bench for prng_tile_pixel_gen (default and zero-seed instances)
module tb_prng_tile_pixel_gen;

   typedef struct {
      bit         chk;
      bit         fs;
      logic [7:0] ea;
      logic [7:0] ez;
      bit         has_pin_a;
      logic [7:0] pin_a;
      bit         has_pin_z;
      logic [7:0] pin_z;
      int         px;
      int         py;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] x_cor = '0;
   logic [9:0] y_cor = '0;
   logic       hold = 1'b0;
   logic [7:0] color_a, color_z;
   logic       fs_a, fs_z;

   int         n_checks = 0;
   int         n_errors = 0;

   sb_t        sb_q[$];
   logic [7:0] seq_a [0:1199];
   logic [7:0] seq_z [0:1199];
   logic [15:0] m_seed_a, m_seed_z;
   int         m_cnt;
   bit         m_active;
   int         b_prev_y;
   bit         g_has_pin_a, g_has_pin_z;
   logic [7:0] g_pin_a, g_pin_z;

   always #5 clk = ~clk;

   prng_tile_pixel_gen dut_a (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_x_cor       (x_cor),
      .i_y_cor       (y_cor),
      .i_hold        (hold),
      .o_color       (color_a),
      .o_frame_start (fs_a)
   );

   prng_tile_pixel_gen #(.SEED(16'h0000)) dut_z (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_x_cor       (x_cor),
      .i_y_cor       (y_cor),
      .i_hold        (hold),
      .o_color       (color_z),
      .o_frame_start (fs_z)
   );

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] b_nxt(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Tile colours in generation order for the frame that is starting
   task automatic build_seq();
      logic [15:0] sa, sz;
      sa = m_seed_a;
      sz = m_seed_z;
      for (int k = 0; k < 1200; k++) begin
         seq_a[k] = sa[7:0];
         seq_z[k] = sz[7:0];
         sa = b_nxt(sa);
         sz = b_nxt(sz);
      end
   endtask

   task automatic sb_pop();
      sb_t e;
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check_val($sformatf("frame_start_a x=%0d y=%0d", e.px, e.py), {7'd0, fs_a}, {7'd0, e.fs});
      check_val($sformatf("frame_start_z x=%0d y=%0d", e.px, e.py), {7'd0, fs_z}, {7'd0, e.fs});
      if (e.chk) begin
         check_val($sformatf("color_a x=%0d y=%0d", e.px, e.py), color_a, e.ea);
         check_val($sformatf("color_z x=%0d y=%0d", e.px, e.py), color_z, e.ez);
      end
      if (e.has_pin_a) check_val($sformatf("pin_a x=%0d y=%0d", e.px, e.py), color_a, e.pin_a);
      if (e.has_pin_z) check_val($sformatf("pin_z x=%0d y=%0d", e.px, e.py), color_z, e.pin_z);
   endtask

   // Drive one coordinate and push what both instances must show one cycle later
   task automatic pix(input int px, input int py, input bit chk, input int gidx);
      sb_t e;
      bit  fs;
      @(negedge clk);
      sb_pop();
      fs = (b_prev_y != 0) && (py == 0);
      if (fs) begin
         m_active = 1'b1;
         build_seq();
         if (!hold) begin
            if (m_cnt == 59) begin
               m_cnt    = 0;
               m_seed_a = b_nxt(m_seed_a);
               m_seed_z = b_nxt(m_seed_z);
            end else begin
               m_cnt++;
            end
         end
      end
      b_prev_y    = py;
      e.chk       = chk;
      e.fs        = fs;
      e.px        = px;
      e.py        = py;
      e.ea        = (m_active && gidx >= 0) ? seq_a[gidx] : 8'h00;
      e.ez        = (m_active && gidx >= 0) ? seq_z[gidx] : 8'h00;
      e.has_pin_a = g_has_pin_a;
      e.pin_a     = g_pin_a;
      e.has_pin_z = g_has_pin_z;
      e.pin_z     = g_pin_z;
`ifdef PRNG_TILE_GRID_EN
      if (m_active && ((px % 16) == 0 || (py % 16) == 0)) begin
         e.ea    = 8'hFF;
         e.ez    = 8'hFF;
         e.pin_a = 8'hFF;
         e.pin_z = 8'hFF;
      end
`endif
      x_cor = px[9:0];
      y_cor = py[9:0];
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      sb_pop();
      rst   = 1'b1;
      x_cor = '0;
      y_cor = '0;
      #1;
      check_val("reset_color_a", color_a, 8'h00);
      check_val("reset_color_z", color_z, 8'h00);
      check_val("reset_fs_a", {7'd0, fs_a}, 8'h00);
      sb_q.delete();
      m_active = 1'b0;
      m_cnt    = 0;
      m_seed_a = 16'hACE1;
      m_seed_z = 16'h0001;
      b_prev_y = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One frame of back-to-back raster lines; pins are tile (0,0)/(1,0) constants, -1 for none
   task automatic frame_raster(input int nlines, input int width,
                               input int p00a, input int p10a, input int p00z, input int p10z);
      pix(0, 1, 1'b0, 0);
      for (int ly = 0; ly < nlines; ly++) begin
         for (int lx = 0; lx < width; lx++) begin
            g_has_pin_a = 1'b0;
            g_has_pin_z = 1'b0;
            if (ly == 0 && lx == 0) begin
               g_has_pin_a = (p00a >= 0); g_pin_a = p00a[7:0];
               g_has_pin_z = (p00z >= 0); g_pin_z = p00z[7:0];
            end
            if (ly == 0 && lx == 16) begin
               g_has_pin_a = (p10a >= 0); g_pin_a = p10a[7:0];
               g_has_pin_z = (p10z >= 0); g_pin_z = p10z[7:0];
            end
            pix(lx, ly, 1'b1, (ly / 16) * 40 + lx / 16);
         end
         g_has_pin_a = 1'b0;
         g_has_pin_z = 1'b0;
         if (ly == 1) begin
            pix(640, 1, 1'b1, -1);
            pix(1023, 1, 1'b1, -1);
         end
      end
   endtask

   initial begin
      g_has_pin_a = 1'b0;
      g_has_pin_z = 1'b0;
      g_pin_a     = 8'h00;
      g_pin_z     = 8'h00;
      do_reset();

      // Idle: coordinates move but no frame start has been seen yet
      for (int i = 0; i < 40; i++) pix(i, 3, 1'b1, 0);

      // First frame: tile row 0 fill, replay lines 1..15, tile row 1 fill
      frame_raster(17, 640, 8'hE1, 8'hC3, 8'h01, 8'h02);

      // Mid-line reset, then output stays 0 until the next frame start
      for (int i = 100; i < 120; i++) pix(i, 17, 1'b1, 40 + i / 16);
      do_reset();
      for (int i = 0; i < 48; i++) pix(i, 5, 1'b1, 0);

      // 61 frames with the counter running: frame 61 uses the advanced seed
      for (int f = 1; f <= 61; f++) begin
         if (f == 61) frame_raster(1, 32, 8'hC3, -1, 8'h02, -1);
         else if (f == 60) frame_raster(1, 32, 8'hE1, -1, 8'h01, -1);
         else frame_raster(1, 32, -1, -1, -1, -1);
      end

      // Same with hold asserted throughout: seed never advances
      do_reset();
      hold = 1'b1;
      for (int f = 1; f <= 61; f++) begin
         if (f == 61) frame_raster(1, 32, 8'hE1, -1, 8'h01, -1);
         else frame_raster(1, 32, -1, -1, -1, -1);
      end
      hold = 1'b0;

      // 1000 back-to-back tile generations: every cycle crosses a tile column
      pix(0, 1, 1'b0, 0);
      for (int k = 0; k <= 1000; k++) pix((k % 2) ? 16 : 0, 0, 1'b1, k);

      @(negedge clk);
      sb_pop();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
